// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_responder
//   Memory slave for the multicycle RV32I core. Each mem_read/mem_write request
//   is answered with a one-cycle mem_resp pulse LATENCY cycles after the
//   request is first seen in IDLE. The backing store is a word-addressed array
//   of 2^ADDR_WIDTH 32-bit words with per-byte write enables.
//
// Parameters
//   ADDR_WIDTH : word-index bits (capacity 2^ADDR_WIDTH words)
//   LATENCY    : cycles from request acceptance to mem_resp, legal 1..15
//
// Ports
//   clk             : rising-edge clock
//   rst_n           : asynchronous active-low reset
//   mem_read        : read request, held high by the core until mem_resp
//   mem_write       : write request, held high by the core until mem_resp
//   mem_address     : byte address, bits [1:0] ignored
//   mem_wdata       : write data
//   mem_byte_enable : per-byte write enable (bit i covers bits [8i+7:8i])
//   mem_resp        : one-cycle completion pulse (decode of the RESP state)
//   mem_rdata       : registered read data, valid while mem_resp is high
//   mem_err         : sticky protocol/range error flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       commit;

  logic [31:0] mem_array [DEPTH];

  // Request and address decode. The shift covers ADDR_WIDTH up to 30, where
  // every address is in range.
  logic                  req;
  logic                  conflict;
  logic                  out_of_range;
  logic                  access_ok;
  logic [ADDR_WIDTH-1:0] word_idx;

  assign req          = mem_read | mem_write;
  assign conflict     = mem_read & mem_write;
  assign out_of_range = (mem_address >> (ADDR_WIDTH + 2)) != 32'd0;
  assign access_ok    = !conflict && !out_of_range;
  assign word_idx     = mem_address[ADDR_WIDTH+1:2];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  //   The counter holds the number of cycles left before the COMMIT edge, so
  //   COMMIT always lands in cycle LATENCY-1 and RESP in cycle LATENCY. With
  //   LATENCY=1 the acceptance cycle in IDLE is itself the commit cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path through the
  // case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            state_nxt = S_RESP;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt   = LAT_M1;
            state_nxt = (LAT_M1 == 4'd1) ? S_COMMIT : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          // Core withdrew the request: abort with nothing committed.
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd2) state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // The commit happens even if the request dropped this cycle.
        state_nxt = S_RESP;
        cnt_nxt   = 4'd0;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_resp = (state == S_RESP);
    commit   = (state == S_COMMIT) ||
               ((LATENCY == 1) && (state == S_IDLE) && req);
  end

  // ---------------------------------------------------------------------------
  // Read data and error flag, updated at the commit edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= 32'd0;
      mem_err   <= 1'b0;
    end else if (commit) begin
      if (access_ok && mem_read) mem_rdata <= mem_array[word_idx];
      else                       mem_rdata <= 32'd0;
      if (!access_ok) mem_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Backing array
  // ---------------------------------------------------------------------------
  // rst_n gates the write so an access caught by reset never lands in the array.
  logic wr_en;
  assign wr_en = commit && access_ok && mem_write && rst_n;

  // NOTE: the array has no reset; its contents must survive rst_n and a
  // memory of this size should map onto RAM rather than flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_byte_enable[b]) mem_array[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Four responders with LATENCY 2, 1, 3 and 5 share clock and reset. Requests
//   are driven and outputs sampled on the falling edge. Cycle 0 of an access is
//   the cycle in which the responder first sees the request while idle.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int N = 4;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd   [N];
  logic        wr   [N];
  logic [31:0] addr [N];
  logic [31:0] wd   [N];
  logic [3:0]  be   [N];
  logic        resp [N];
  logic [31:0] rdat [N];
  logic        err  [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.ADDR_WIDTH(8), .LATENCY(lat_of(g))) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_read        (rd[g]),
      .mem_write       (wr[g]),
      .mem_address     (addr[g]),
      .mem_wdata       (wd[g]),
      .mem_byte_enable (be[g]),
      .mem_resp        (resp[g]),
      .mem_rdata       (rdat[g]),
      .mem_err         (err[g])
    );
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a request (at a falling edge) and wait for mem_resp. 'start' is the
  // cycle number of the next falling edge: 1 when the request is raised in an
  // idle cycle, 0 when it is raised during the previous access's RESP cycle.
  // Returns the cycle in which mem_resp was seen (-1 on timeout).
  task automatic access(input int i, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input int start,
                        output int rc, output logic [31:0] rv, output logic ev);
    rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d; be[i] = b;
    rc = -1; rv = 32'hx; ev = 1'bx;
    for (int k = start; k <= lat_of(i) + 4; k++) begin
      @(negedge clk);
      if (resp[i] === 1'b1) begin
        rc = k; rv = rdat[i]; ev = err[i];
        break;
      end
    end
  endtask

  task automatic idle(input int i);
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] ref_mem [16];
  logic        ref_err;
  int          rc;
  logic [31:0] rv;
  logic        ev;
  logic        chained;
  logic        seen;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB_33DD, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b1};

    // ---- Reset state ----
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wd[i] = 32'd0; be[i] = 4'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset resp[%0d]", i),  32'(resp[i]), 32'd0);
      check($sformatf("reset rdata[%0d]", i), rdat[i],      32'd0);
      check($sformatf("reset err[%0d]", i),   32'(err[i]),  32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // ---- Table vectors on LATENCY=2 ----
    for (int k = 0; k < 14; k++) begin
      access(0, tbl[k].r, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].b, 1, rc, rv, ev);
      check($sformatf("v%0d resp cycle", k), 32'(rc), 32'd2);
      check($sformatf("v%0d rdata", k), rv, tbl[k].exp_rd);
      check($sformatf("v%0d err", k), 32'(ev), 32'(tbl[k].exp_err));
      idle(0);
      check($sformatf("v%0d resp width", k), 32'(resp[0]), 32'd0);
      check($sformatf("v%0d rdata hold", k), rdat[0], tbl[k].exp_rd);
    end

    // ---- Latency sweep: LATENCY=1 and 5, back-to-back with no gap ----
    for (int i = 1; i < N; i += 2) begin
      for (int j = 0; j < 4; j++) begin
        access(i, 1'b0, 1'b1, 32'(j * 4), 32'hA500_0000 | 32'(i << 8) | 32'(j), 4'hF,
               (j == 0) ? 1 : 0, rc, rv, ev);
        check($sformatf("sweep L%0d wr%0d cycle", lat_of(i), j), 32'(rc), 32'(lat_of(i)));
      end
      for (int j = 0; j < 4; j++) begin
        access(i, 1'b1, 1'b0, 32'(j * 4), 32'd0, 4'h0, 0, rc, rv, ev);
        check($sformatf("sweep L%0d rd%0d cycle", lat_of(i), j), 32'(rc), 32'(lat_of(i)));
        check($sformatf("sweep L%0d rd%0d data", lat_of(i), j), rv,
              32'hA500_0000 | 32'(i << 8) | 32'(j));
      end
      idle(i);
      check($sformatf("sweep L%0d resp width", lat_of(i)), 32'(resp[i]), 32'd0);
    end

    // ---- Abort on LATENCY=3: write dropped in cycle 1 ----
    access(2, 1'b0, 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 1, rc, rv, ev);
    check("abort preload cycle", 32'(rc), 32'd3);
    idle(2);
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h30; wd[2] = 32'hFFFF_FFFF; be[2] = 4'hF;
    @(negedge clk);
    seen = resp[2];
    wr[2] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp[2] === 1'b1) seen = 1'b1;
    end
    check("abort no resp", 32'(seen), 32'd0);
    access(2, 1'b1, 1'b0, 32'h30, 32'd0, 4'h0, 1, rc, rv, ev);
    check("abort read data", rv, 32'h0BAD_F00D);
    check("abort err", 32'(ev), 32'd0);
    idle(2);

    // ---- Reset in WAIT during a write to 0x40 (LATENCY=3) ----
    access(2, 1'b0, 1'b1, 32'h40, 32'h4040_4040, 4'hF, 1, rc, rv, ev);
    access(2, 1'b0, 1'b1, 32'h44, 32'h4444_4444, 4'hF, 0, rc, rv, ev);
    access(2, 1'b1, 1'b0, 32'h44, 32'd0, 4'h0, 0, rc, rv, ev);
    check("rst pre read", rv, 32'h4444_4444);
    idle(2);
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h40; wd[2] = 32'h0; be[2] = 4'hF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst async resp", 32'(resp[2]), 32'd0);
    check("rst async rdata", rdat[2], 32'd0);
    check("rst async err", 32'(err[2]), 32'd0);
    check("rst clears sticky err", 32'(err[0]), 32'd0);
    wr[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(2, 1'b1, 1'b0, 32'h40, 32'd0, 4'h0, 1, rc, rv, ev);
    check("rst read 0x40", rv, 32'h4040_4040);
    access(2, 1'b1, 1'b0, 32'h44, 32'd0, 4'h0, 0, rc, rv, ev);
    check("rst read 0x44", rv, 32'h4444_4444);
    access(2, 1'b1, 1'b0, 32'h30, 32'd0, 4'h0, 0, rc, rv, ev);
    check("rst read 0x30", rv, 32'h0BAD_F00D);
    check("rst read err", 32'(ev), 32'd0);
    idle(2);

    // ---- Randomized traffic on LATENCY=2 against a reference model ----
    ref_err = 1'b0;
    for (int j = 0; j < 16; j++) begin
      ref_mem[j] = $urandom;
      access(0, 1'b0, 1'b1, 32'(j * 4), ref_mem[j], 4'hF, (j == 0) ? 1 : 0, rc, rv, ev);
    end
    idle(0);
    chained = 1'b0;
    for (int n = 0; n < 200; n++) begin
      int unsigned op;
      logic        r, w, oor;
      logic [31:0] a, d, exp_rd;
      logic [3:0]  b;
      op = $urandom_range(0, 19);
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
      d  = $urandom;
      b  = 4'($urandom);
      r  = (op <= 9);
      w  = (op == 0) || (op >= 10);
      if (op == 1) a = a | (32'h1 << $urandom_range(10, 31));
      oor = (a[31:10] != 22'd0);
      exp_rd = 32'd0;
      if ((r && w) || oor) begin
        ref_err = 1'b1;
      end else if (r) begin
        exp_rd = ref_mem[a[5:2]];
      end else begin
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[a[5:2]][8*k +: 8] = d[8*k +: 8];
      end
      access(0, r, w, a, d, b, chained ? 0 : 1, rc, rv, ev);
      check($sformatf("rand%0d cycle", n), 32'(rc), 32'd2);
      check($sformatf("rand%0d rdata a=%h r=%0b w=%0b", n, a, r, w), rv, exp_rd);
      check($sformatf("rand%0d err", n), 32'(ev), 32'(ref_err));
      if ($urandom_range(0, 1) == 1) chained = 1'b1;
      else begin
        idle(0);
        chained = 1'b0;
      end
    end
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
